// File: rtl/xmit_frame_feeder_pkg.sv
// xmit_pkg: shared types and helpers for the transmit frame feeder.
package xmit_pkg;

    localparam int CTRL_W = 24;
    localparam int LEN_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Both halves carry the same length: the upper half is used for buffer
    // allocation downstream, the lower half by the PHY byte counter.
    function automatic logic [CTRL_W-1:0] pack_ctrl(input logic [LEN_W-1:0] len);
        return {len, len};
    endfunction

endpackage

// File: rtl/xmit_frame_feeder_ram.sv
// xmit_frame_ram: simple dual-port frame buffer, one write port, one registered read port.
module xmit_frame_ram #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_sys,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk_sys) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read port, free-running.
    always_ff @(posedge clk_sys) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/xmit_frame_feeder.sv
// xmit_frame_feeder: store-and-forward buffer upstream of the transmit top level.
// Build macro XMIT_FEEDER_PAD_EN: when defined, runt frames are padded with 0x00
// up to MIN_LEN bytes; when undefined they are dropped and counted.
//
// state | meaning
// IDLE  | waiting for a start-of-frame byte
// FILL  | writing frame bytes into the buffer
// SEND  | replaying the buffered frame on the f_* interface
// GAP   | holding the inter-frame idle gap
module xmit_frame_feeder
    import xmit_pkg::*;
#(
    parameter int DEPTH   = 2048,
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64,
    parameter int IFG     = 10
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic              in_hi_priority,
    output logic              in_ready,
    output logic [7:0]        f_data_in,
    output logic              f_rec_data_valid,
    output logic              f_rec_frame_valid,
    output logic [CTRL_W-1:0] f_ctrl_in,
    output logic              f_hi_priority,
    output logic [7:0]        drop_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int GAP_W = $clog2(IFG + 1);
    localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] MIN_L    = LEN_W'(MIN_LEN);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG - 1);

    state_t           state;
    logic [LEN_W-1:0] len, send_len, rd_cnt, close_len;
    logic [GAP_W-1:0] gap_cnt;
    logic             prio, ovs;
    logic             accept, start, abort, room, do_close, do_drop, rd_issue;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [7:0]       ram_q;
    logic             p1_vld, p1_first, p1_pad;
    logic [8:0]       drop_sum;

    assign in_ready  = (state == ST_IDLE) || (state == ST_FILL);
    assign accept    = in_valid && in_ready;
    assign start     = accept && in_sof;
    assign abort     = start && (state == ST_FILL);
    // A non-sof byte in FILL has a slot only while the frame is below MAX_LEN.
    assign room      = (state == ST_FILL) && !ovs && (len != MAX_L);
    assign close_len = start ? LEN_W'(1) : len + LEN_W'(1);
    assign rd_issue  = (state == ST_SEND) && (rd_cnt != send_len);
    assign drop_sum  = {1'b0, drop_cnt} + {8'd0, abort} + {8'd0, do_drop};

    // Classify the current beat: buffer write, frame close or frame drop.
    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = '0;
        do_close = 1'b0;
        do_drop  = 1'b0;
        if (start) begin
            wr_en = 1'b1;
        end else if (accept && room) begin
            wr_en   = 1'b1;
            wr_addr = len[AW-1:0];
        end
        if (accept && in_eof) begin
            if (start || room) begin
                if (close_len < MIN_L) begin
`ifdef XMIT_FEEDER_PAD_EN
                    do_close = 1'b1;
`else
                    do_drop  = 1'b1;
`endif
                end else begin
                    do_close = 1'b1;
                end
            end else if (state == ST_FILL) begin
                do_drop = 1'b1;
            end
        end
    end

    xmit_frame_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk_sys (clk_sys),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_addr (rd_cnt[AW-1:0]),
        .rd_data (ram_q)
    );

    // Main FSM with length, read and gap counters.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            len      <= '0;
            send_len <= '0;
            rd_cnt   <= '0;
            gap_cnt  <= '0;
            prio     <= 1'b0;
            ovs      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_FILL: begin
                    if (start) prio <= in_hi_priority;
                    if (do_close) begin
                        state  <= ST_SEND;
                        len    <= close_len;
                        rd_cnt <= '0;
                        ovs    <= 1'b0;
`ifdef XMIT_FEEDER_PAD_EN
                        send_len <= (close_len < MIN_L) ? MIN_L : close_len;
`else
                        send_len <= close_len;
`endif
                    end else if (do_drop) begin
                        state <= ST_IDLE;
                        len   <= '0;
                        ovs   <= 1'b0;
                    end else if (start) begin
                        state <= ST_FILL;
                        len   <= LEN_W'(1);
                        ovs   <= 1'b0;
                    end else if (accept && (state == ST_FILL)) begin
                        if (room) len <= len + LEN_W'(1);
                        else      ovs <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (rd_issue) begin
                        rd_cnt <= rd_cnt + LEN_W'(1);
                    end else if (!p1_vld) begin
                        state   <= ST_GAP;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                        len   <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read-side pipeline tags aligned with the registered RAM output.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            p1_vld   <= 1'b0;
            p1_first <= 1'b0;
            p1_pad   <= 1'b0;
        end else begin
            p1_vld   <= rd_issue;
            p1_first <= rd_issue && (rd_cnt == '0);
            p1_pad   <= rd_cnt >= len;
        end
    end

    // Output registers towards the transmit top level.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            f_data_in         <= '0;
            f_rec_data_valid  <= 1'b0;
            f_rec_frame_valid <= 1'b0;
            f_ctrl_in         <= '0;
            f_hi_priority     <= 1'b0;
        end else begin
            f_data_in         <= (p1_vld && !p1_pad) ? ram_q : 8'h00;
            f_rec_data_valid  <= p1_vld;
            f_rec_frame_valid <= p1_vld && p1_first;
            f_ctrl_in         <= (p1_vld && p1_first) ? pack_ctrl(send_len) : '0;
            if (p1_vld && p1_first)
                f_hi_priority <= prio;
            else if ((state == ST_GAP) && (gap_cnt == '0))
                f_hi_priority <= 1'b0;
        end
    end

    // Saturating dropped-frame counter.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) drop_cnt <= '0;
        else       drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

endmodule

// File: tb/tb_xmit_frame_feeder.sv
// Self-checking bench for xmit_frame_feeder with a frame-level reference model.
module tb_xmit_frame_feeder;

    localparam int MAX_LEN = 1518;
    localparam int MIN_LEN = 64;
    localparam int IFG     = 10;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, in_hi_priority = 1'b0;
    logic        in_ready;
    logic [7:0]  f_data_in;
    logic        f_rec_data_valid, f_rec_frame_valid, f_hi_priority;
    logic [23:0] f_ctrl_in;
    logic [7:0]  drop_cnt;

    xmit_frame_feeder dut (
        .clk_sys           (clk_sys),
        .reset             (reset),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_sof            (in_sof),
        .in_eof            (in_eof),
        .in_hi_priority    (in_hi_priority),
        .in_ready          (in_ready),
        .f_data_in         (f_data_in),
        .f_rec_data_valid  (f_rec_data_valid),
        .f_rec_frame_valid (f_rec_frame_valid),
        .f_ctrl_in         (f_ctrl_in),
        .f_hi_priority     (f_hi_priority),
        .drop_cnt          (drop_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Reference model state: expected bursts in order.
    byte unsigned tx_q[$];
    byte unsigned exp_byte_q[$];
    int           exp_len_q[$];
    bit           exp_prio_q[$];
    int           exp_eof_q[$];
    int           exp_drops = 0;

    // Monitor state.
    int  bursts_seen = 0;
    int  mon_idx = 0;
    bit  in_burst = 0;
    int  cur_len = 0;
    bit  cur_prio = 0;
    int  prev_last = -1000;
    int  eofc = 0;
    int  last_ctrl = 0;
    byte unsigned eb;

    // Output monitor: checks each burst against the model queues.
    always @(negedge clk_sys) begin
        if (reset) begin
            in_burst  = 0;
            mon_idx   = 0;
            prev_last = -1000;
        end else begin
            if (f_rec_frame_valid && !in_burst) begin
                total++;
                if (exp_len_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_frame ctrl=%h", f_ctrl_in);
                    cur_len = 0;
                end else begin
                    cur_len  = exp_len_q.pop_front();
                    cur_prio = exp_prio_q.pop_front();
                    eofc     = (exp_eof_q.size() != 0) ? exp_eof_q.pop_front() : -1;
                    if (f_ctrl_in !== 24'((cur_len << 12) + cur_len)) begin
                        bad++;
                        $display("FAIL ctrl got=%h exp=%h", f_ctrl_in, 24'((cur_len << 12) + cur_len));
                    end
                    total++;
                    if (cyc - eofc != 2) begin
                        bad++;
                        $display("FAIL latency got=%0d exp=2", cyc - eofc);
                    end
                    total++;
                    if (cyc - prev_last < IFG + 1) begin
                        bad++;
                        $display("FAIL ifg got=%0d exp>=%0d", cyc - prev_last, IFG + 1);
                    end
                end
                last_ctrl = int'(f_ctrl_in);
                bursts_seen++;
                in_burst = 1;
                mon_idx  = 0;
            end else if (f_rec_frame_valid) begin
                total++; bad++;
                $display("FAIL frame_valid_repeat idx=%0d got=1 exp=0", mon_idx);
            end
            if (in_burst) begin
                if (f_rec_data_valid) begin
                    total++;
                    if (mon_idx >= cur_len) begin
                        bad++;
                        $display("FAIL burst_overrun idx=%0d exp_len=%0d", mon_idx, cur_len);
                    end else begin
                        eb = exp_byte_q.pop_front();
                        if (f_data_in !== eb) begin
                            bad++;
                            $display("FAIL byte[%0d] got=%h exp=%h", mon_idx, f_data_in, eb);
                        end
                    end
                    total++;
                    if (f_hi_priority !== cur_prio) begin
                        bad++;
                        $display("FAIL hi_priority idx=%0d got=%b exp=%b", mon_idx, f_hi_priority, cur_prio);
                    end
                    if (mon_idx > 0) begin
                        total++;
                        if (f_ctrl_in !== 24'h0) begin
                            bad++;
                            $display("FAIL ctrl_hold idx=%0d got=%h exp=0", mon_idx, f_ctrl_in);
                        end
                    end
                    mon_idx++;
                    prev_last = cyc;
                end else begin
                    total++;
                    if (mon_idx != cur_len) begin
                        bad++;
                        $display("FAIL burst_len got=%0d exp=%0d", mon_idx, cur_len);
                    end
                    for (int k = mon_idx; k < cur_len; k++)
                        if (exp_byte_q.size() != 0) void'(exp_byte_q.pop_front());
                    in_burst = 0;
                end
            end else if (f_rec_data_valid) begin
                total++; bad++;
                $display("FAIL stray_data got=%h", f_data_in);
            end
        end
    end

    task automatic fill_random(input int n);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
    endtask

    // Frame-level model: what the block should emit for a complete frame of n bytes.
    task automatic model_frame(input int n, input bit prio, output bit sent);
        int out_len;
        sent = 0;
        out_len = n;
        if (n > MAX_LEN) begin
            exp_drops++;
            return;
        end
        if (n < MIN_LEN) begin
`ifdef XMIT_FEEDER_PAD_EN
            out_len = MIN_LEN;
`else
            exp_drops++;
            return;
`endif
        end
        for (int i = 0; i < out_len; i++)
            exp_byte_q.push_back((i < n) ? tx_q[i] : 8'h00);
        exp_len_q.push_back(out_len);
        exp_prio_q.push_back(prio);
        sent = 1;
    endtask

    // Drives tx_q[0..n-1] as one frame; returns at the negedge after the last beat.
    task automatic drive_frame(input int n, input bit prio, input bit with_eof,
                               input bit bubbles, output int eof_cyc);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            if (bubbles && ($urandom_range(0, 3) == 0)) begin
                in_valid = 0;
                @(negedge clk_sys);
            end
            while (!in_ready) begin
                in_valid = 0;
                @(negedge clk_sys);
                w++;
                if (w > 5000) begin
                    total++; bad++;
                    $display("FAIL drive_timeout in_ready got=0 exp=1");
                    $display("test done: total=%0d bad=%0d", total, bad);
                    $fatal(1, "in_ready stuck low");
                end
            end
            in_valid       = 1;
            in_data        = tx_q[i];
            in_sof         = (i == 0);
            in_eof         = with_eof && (i == n - 1);
            in_hi_priority = prio;
            @(negedge clk_sys);
        end
        eof_cyc  = cyc;
        in_valid = 0;
        in_sof   = 0;
        in_eof   = 0;
    endtask

    task automatic send_frame(input int n, input bit prio, input bit bubbles);
        bit sent;
        int ec;
        model_frame(n, prio, sent);
        drive_frame(n, prio, 1'b1, bubbles, ec);
        if (sent) exp_eof_q.push_back(ec);
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((exp_len_q.size() != 0 || in_burst || !in_ready || f_rec_data_valid) && w < 6000) begin
            @(negedge clk_sys);
            w++;
        end
        if (w >= 6000) begin
            total++; bad++;
            $display("FAIL drain_timeout pending=%0d in_ready=%b", exp_len_q.size(), in_ready);
        end
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic apply_reset();
        reset    = 1;
        in_valid = 0; in_sof = 0; in_eof = 0;
        repeat (2) @(negedge clk_sys);
        exp_byte_q.delete(); exp_len_q.delete(); exp_prio_q.delete(); exp_eof_q.delete();
        exp_drops = 0;
        reset = 0;
        @(negedge clk_sys);
    endtask

    task automatic test_reset();
        reset = 1;
        @(negedge clk_sys);
        total++; if (in_ready !== 1'b1)         begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        total++; if (f_rec_data_valid !== 1'b0) begin bad++; $display("FAIL rst_data_valid got=%b exp=0", f_rec_data_valid); end
        total++; if (f_rec_frame_valid !== 1'b0) begin bad++; $display("FAIL rst_frame_valid got=%b exp=0", f_rec_frame_valid); end
        total++; if (f_ctrl_in !== 24'h0)       begin bad++; $display("FAIL rst_ctrl got=%h exp=0", f_ctrl_in); end
        total++; if (f_data_in !== 8'h0)        begin bad++; $display("FAIL rst_data got=%h exp=0", f_data_in); end
        total++; if (f_hi_priority !== 1'b0)    begin bad++; $display("FAIL rst_prio got=%b exp=0", f_hi_priority); end
        total++; if (drop_cnt !== 8'h0)         begin bad++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt); end
        reset = 0;
        @(negedge clk_sys);
    endtask

    task automatic test_basic_64();
        int b0;
        apply_reset();
        tx_q.delete();
        for (int i = 0; i < 64; i++) tx_q.push_back((i < 4 || i >= 60) ? 8'hFF : 8'h00);
        b0 = bursts_seen;
        send_frame(64, 1'b0, 1'b0);
        wait_drain();
        total++; if (bursts_seen != b0 + 1) begin bad++; $display("FAIL basic_bursts got=%0d exp=%0d", bursts_seen - b0, 1); end
        total++; if (last_ctrl != 32'h040040) begin bad++; $display("FAIL basic_ctrl got=%h exp=040040", last_ctrl); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL basic_drop got=%0d exp=0", drop_cnt); end
    endtask

    task automatic test_back_to_back();
        int b0;
        int low_cnt;
        apply_reset();
        b0 = bursts_seen;
        fill_random(64);
        send_frame(64, 1'b0, 1'b0);
        fill_random(64);
        low_cnt = 0;
        fork
            send_frame(64, 1'b1, 1'b0);
            begin
                while (!in_ready && low_cnt < 500) begin
                    low_cnt++;
                    @(negedge clk_sys);
                end
            end
        join
        total++;
        if (low_cnt != 64 + 2 + IFG) begin
            bad++;
            $display("FAIL b2b_ready_low got=%0d exp=%0d", low_cnt, 64 + 2 + IFG);
        end
        wait_drain();
        total++; if (bursts_seen != b0 + 2) begin bad++; $display("FAIL b2b_bursts got=%0d exp=2", bursts_seen - b0); end
    endtask

    task automatic test_runt();
        int b0;
        apply_reset();
        b0 = bursts_seen;
        fill_random(40);
        send_frame(40, 1'($urandom), 1'b0);
        wait_drain();
`ifdef XMIT_FEEDER_PAD_EN
        total++; if (bursts_seen != b0 + 1) begin bad++; $display("FAIL runt_bursts got=%0d exp=1", bursts_seen - b0); end
        total++; if (last_ctrl != 32'h040040) begin bad++; $display("FAIL runt_ctrl got=%h exp=040040", last_ctrl); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL runt_drop got=%0d exp=0", drop_cnt); end
`else
        total++; if (bursts_seen != b0) begin bad++; $display("FAIL runt_bursts got=%0d exp=0", bursts_seen - b0); end
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL runt_drop got=%0d exp=1", drop_cnt); end
`endif
    endtask

    task automatic test_oversize_then_max();
        int b0;
        apply_reset();
        b0 = bursts_seen;
        fill_random(MAX_LEN + 1);
        send_frame(MAX_LEN + 1, 1'b0, 1'b0);
        wait_drain();
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL over_drop got=%0d exp=1", drop_cnt); end
        total++; if (bursts_seen != b0) begin bad++; $display("FAIL over_bursts got=%0d exp=0", bursts_seen - b0); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL over_idle in_ready got=%b exp=1", in_ready); end
        fill_random(MAX_LEN);
        send_frame(MAX_LEN, 1'b1, 1'b0);
        wait_drain();
        total++; if (last_ctrl != 32'h5EE5EE) begin bad++; $display("FAIL max_ctrl got=%h exp=5ee5ee", last_ctrl); end
        total++; if (bursts_seen != b0 + 1) begin bad++; $display("FAIL max_bursts got=%0d exp=1", bursts_seen - b0); end
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL max_drop got=%0d exp=1", drop_cnt); end
    endtask

    task automatic test_abort();
        int b0;
        int ec;
        apply_reset();
        b0 = bursts_seen;
        fill_random(20);
        drive_frame(20, 1'b0, 1'b0, 1'b0, ec);
        exp_drops++;
        fill_random(64);
        send_frame(64, 1'b1, 1'b0);
        wait_drain();
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL abort_drop got=%0d exp=1", drop_cnt); end
        total++; if (bursts_seen != b0 + 1) begin bad++; $display("FAIL abort_bursts got=%0d exp=1", bursts_seen - b0); end
    endtask

    task automatic test_random();
        int b0;
        int n_exp;
        int n;
        int pre;
        apply_reset();
        b0 = bursts_seen;
        n_exp = 0;
        for (int f = 0; f < 10; f++) begin
            pre = exp_len_q.size() + n_exp;
            if ($urandom_range(0, 2) == 0) begin
                // Bytes with no sof while idle must be ignored.
                for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
                    in_valid = 1; in_sof = 0; in_eof = 1'($urandom);
                    in_data = 8'($urandom);
                    @(negedge clk_sys);
                end
                in_valid = 0; in_eof = 0;
            end
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MIN_LEN - 1))
                                            : int'($urandom_range(MIN_LEN, 200));
            fill_random(n);
            send_frame(n, 1'($urandom), 1'b1);
            if (exp_len_q.size() + n_exp > pre) n_exp++;
            repeat ($urandom_range(0, 3)) @(negedge clk_sys);
        end
        wait_drain();
        total++; if (drop_cnt !== 8'(exp_drops)) begin bad++; $display("FAIL rand_drop got=%0d exp=%0d", drop_cnt, exp_drops); end
        total++; if (bursts_seen - b0 != n_exp) begin bad++; $display("FAIL rand_bursts got=%0d exp=%0d", bursts_seen - b0, n_exp); end
    endtask

    task automatic test_reset_during_send();
        int w;
        int b0;
        int seen;
        apply_reset();
        fill_random(64);
        send_frame(64, 1'b1, 1'b0);
        w = 0;
        while (!(in_burst && mon_idx == 30) && w < 300) begin
            @(negedge clk_sys);
            w++;
        end
        total++;
        if (w >= 300) begin bad++; $display("FAIL rsend_timeout idx=%0d exp=30", mon_idx); end
        reset = 1;
        #1;
        total++; if (f_rec_data_valid !== 1'b0) begin bad++; $display("FAIL rsend_async_valid got=%b exp=0", f_rec_data_valid); end
        @(negedge clk_sys);
        total++; if (f_rec_data_valid !== 1'b0 || f_rec_frame_valid !== 1'b0 || f_ctrl_in !== 24'h0 ||
                     f_data_in !== 8'h0 || f_hi_priority !== 1'b0) begin
            bad++;
            $display("FAIL rsend_outputs got=%b%b%h%h%b exp=all zero", f_rec_data_valid, f_rec_frame_valid,
                     f_ctrl_in, f_data_in, f_hi_priority);
        end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rsend_ready got=%b exp=1", in_ready); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rsend_drop got=%0d exp=0", drop_cnt); end
        exp_byte_q.delete(); exp_len_q.delete(); exp_prio_q.delete(); exp_eof_q.delete();
        reset = 0;
        b0 = bursts_seen;
        seen = 0;
        repeat (100) begin
            @(negedge clk_sys);
            if (f_rec_data_valid || f_rec_frame_valid) seen++;
        end
        total++; if (seen != 0 || bursts_seen != b0) begin bad++; $display("FAIL rsend_reissue got=%0d exp=0", seen); end
    endtask

    initial begin
        #900000;
        total++; bad++;
        $display("FAIL watchdog time=%0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_sys);
        test_reset();
        test_basic_64();
        test_back_to_back();
        test_runt();
        test_oversize_then_max();
        test_abort();
        test_random();
        test_reset_during_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
